// File: rtl/seg7_scan_ctrl_if.sv
// Host-side bundle for the 7-segment scan controller: scan enable, double-buffered
// data load, and the registered display drive outputs.
interface seg7_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    en;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] data_in;
  logic                    busy;
  logic [3:0]              bcd_out;
  logic [NUM_DIGITS-1:0]   dig_sel;
  logic                    frame_tick;

  modport master (
    output en, load, data_in,
    input  busy, bcd_out, dig_sel, frame_tick
  );

  modport slave (
    input  en, load, data_in,
    output busy, bcd_out, dig_sel, frame_tick
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed common-cathode 7-segment scan controller with per-slot ghost blanking,
// tear-free double buffering and optional leading-zero suppression.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS    = 4,
  parameter int SLOT_CYCLES   = 1000,
  parameter int BLANK_CYCLES  = 16,
  parameter int BLANK_LEADING = 1
) (
  input logic            clk,
  input logic            rst,
  seg7_scan_ctrl_if.slave bus
);

  localparam int unsigned CW = $clog2(SLOT_CYCLES);
  localparam int unsigned IW = $clog2(NUM_DIGITS);
  localparam int unsigned DW = 4 * NUM_DIGITS;

  localparam logic [CW-1:0] CNT_LAST   = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] SEL_ONE = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

  typedef enum logic {
    BLANK,
    DRIVE
  } state_t;

  state_t                state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [IW-1:0]         idx, idx_n;
  logic                  run, run_n;
  logic                  xfer;

  logic [DW-1:0]         active, active_n;
  logic [DW-1:0]         pending, pending_n;
  logic                  busy, busy_n;

  logic [NUM_DIGITS-1:0] dig_sel, dig_sel_n;
  logic [3:0]            bcd_out, bcd_n;
  logic                  frame_tick, tick_n;

  logic [3:0]            act_dig [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] sup;

  // run marks an active scan; the first enabled cycle after idle/reset restarts
  // at digit-0 BLANK with a frame_tick instead of advancing the counter.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    run_n   = run;
    xfer    = 1'b0;
    tick_n  = 1'b0;
    if (!bus.en) begin
      state_n = BLANK;
      cnt_n   = '0;
      idx_n   = '0;
      run_n   = 1'b0;
      xfer    = 1'b1;
    end else if (!run) begin
      state_n = BLANK;
      cnt_n   = '0;
      idx_n   = '0;
      run_n   = 1'b1;
      xfer    = 1'b1;
      tick_n  = 1'b1;
    end else if (cnt == CNT_LAST) begin
      state_n = BLANK;
      cnt_n   = '0;
      if (idx == IDX_LAST) begin
        idx_n  = '0;
        xfer   = 1'b1;
        tick_n = 1'b1;
      end else begin
        idx_n = idx + 1'b1;
      end
    end else begin
      cnt_n = cnt + 1'b1;
      if (state == BLANK && cnt == BLANK_LAST)
        state_n = DRIVE;
    end
  end

  // Transfer samples the old pending before a coincident load overwrites it.
  always_comb begin
    active_n  = active;
    pending_n = pending;
    busy_n    = busy;
    if (xfer) begin
      active_n = pending;
      busy_n   = 1'b0;
    end
    if (bus.load) begin
      pending_n = bus.data_in;
      busy_n    = 1'b1;
    end
  end

  always_comb begin
    logic all_zero;
    all_zero = 1'b1;
    sup      = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++)
      act_dig[i] = active_n[4*i +: 4];
    for (int unsigned i = NUM_DIGITS - 1; i > 0; i--) begin
      all_zero = all_zero && (act_dig[i] == 4'd0);
      sup[i]   = (BLANK_LEADING != 0) && all_zero;
    end
  end

  // Outputs are registered from the next-state view so dig_sel and bcd_out
  // always change together and line up with the state registers.
  always_comb begin
    dig_sel_n = '0;
    bcd_n     = 4'hF;
    if (state_n == DRIVE) begin
      dig_sel_n = SEL_ONE << idx_n;
      bcd_n     = sup[idx_n] ? 4'hF : act_dig[idx_n];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= BLANK;
      cnt        <= '0;
      idx        <= '0;
      run        <= 1'b0;
      active     <= '0;
      pending    <= '0;
      busy       <= 1'b0;
      dig_sel    <= '0;
      bcd_out    <= 4'hF;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      run        <= run_n;
      active     <= active_n;
      pending    <= pending_n;
      busy       <= busy_n;
      dig_sel    <= dig_sel_n;
      bcd_out    <= bcd_n;
      frame_tick <= tick_n;
    end
  end

  assign bus.busy       = busy;
  assign bus.bcd_out    = bcd_out;
  assign bus.dig_sel    = dig_sel;
  assign bus.frame_tick = frame_tick;

endmodule
